// File: rtl/fib_checker.sv
// Fibonacci stream checker: locks on the 0,1 seed, then checks each valid term against the
// recurrence mod 2^WIDTH. Optional macro FIB_CHECKER_RESYNC_EN reseeds on mismatch instead of failing.
module fib_checker #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     value,
    input  logic                 valid,
    output logic                 locked,
    output logic                 error,
    output logic [CNT_WIDTH-1:0] term_count,
    output logic [WIDTH-1:0]     expected,
    output logic [WIDTH-1:0]     bad_value,
    output logic                 wrapped
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StSeed  = 2'd1;
    localparam logic [1:0] StCheck = 2'd2;
    localparam logic [1:0] StFail  = 2'd3;

    localparam logic [WIDTH-1:0]     One    = WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    logic [1:0]           state_q, state_d;
    logic [WIDTH-1:0]     prev1_q, prev1_d;
    logic [WIDTH-1:0]     expected_q, expected_d;
    logic                 carry_q, carry_d;
    logic                 locked_q, locked_d;
    logic                 error_q, error_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0]     bad_q, bad_d;
    logic                 wrapped_q, wrapped_d;

    logic [CNT_WIDTH-1:0] count_inc;
    logic [WIDTH:0]       sum;

    // The older term only ever feeds the next sum, so it lives folded into expected_q.
    assign sum       = {1'b0, prev1_q} + {1'b0, value};
    assign count_inc = (count_q == '1) ? count_q : count_q + CntOne;

    always_comb begin
        state_d    = state_q;
        prev1_d    = prev1_q;
        expected_d = expected_q;
        carry_d    = carry_q;
        locked_d   = locked_q;
        error_d    = error_q;
        count_d    = count_q;
        bad_d      = bad_q;
        wrapped_d  = wrapped_q;

        if (valid && state_q != StFail) begin
            unique case (state_q)
                StIdle: begin
                    if (value == '0) begin
                        state_d    = StSeed;
                        prev1_d    = '0;
                        expected_d = One;
                        carry_d    = 1'b0;
                        count_d    = count_inc;
                    end else begin
                        state_d  = StFail;
                        error_d  = 1'b1;
                        locked_d = 1'b0;
                        if (!error_q) bad_d = value;
                    end
                end
                StSeed: begin
                    if (value == One) begin
                        state_d    = StCheck;
                        prev1_d    = One;
                        locked_d   = 1'b1;
                        expected_d = One;
                        carry_d    = 1'b0;
                        count_d    = count_inc;
                    end else begin
                        state_d  = StFail;
                        error_d  = 1'b1;
                        locked_d = 1'b0;
                        if (!error_q) bad_d = value;
                    end
                end
                StCheck: begin
                    if (value == expected_q) begin
                        prev1_d               = value;
                        {carry_d, expected_d} = sum;
                        count_d               = count_inc;
                        if (carry_q) wrapped_d = 1'b1;
                    end else begin
`ifdef FIB_CHECKER_RESYNC_EN
                        // Reseed from the last good term and the offending one.
                        error_d               = 1'b1;
                        if (!error_q) bad_d = value;
                        prev1_d               = value;
                        {carry_d, expected_d} = sum;
                        count_d               = count_inc;
`else
                        state_d  = StFail;
                        error_d  = 1'b1;
                        locked_d = 1'b0;
                        if (!error_q) bad_d = value;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            prev1_q    <= '0;
            expected_q <= '0;
            carry_q    <= 1'b0;
            locked_q   <= 1'b0;
            error_q    <= 1'b0;
            count_q    <= '0;
            bad_q      <= '0;
            wrapped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev1_q    <= prev1_d;
            expected_q <= expected_d;
            carry_q    <= carry_d;
            locked_q   <= locked_d;
            error_q    <= error_d;
            count_q    <= count_d;
            bad_q      <= bad_d;
            wrapped_q  <= wrapped_d;
        end
    end

    assign locked     = locked_q;
    assign error      = error_q;
    assign term_count = count_q;
    assign expected   = expected_q;
    assign bad_value  = bad_q;
    assign wrapped    = wrapped_q;

endmodule

// File: tb/tb_fib_checker.sv
// Bench for fib_checker (WIDTH=8, CNT_WIDTH=4): vector table, directed corner sequences and
// random stimulus against a term-history reference model.
module tb_fib_checker;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int CNT_MAX = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  value = '0;
    logic          valid = 1'b0;
    logic          locked;
    logic          error;
    logic [CW-1:0] term_count;
    logic [W-1:0]  expected;
    logic [W-1:0]  bad_value;
    logic          wrapped;

    fib_checker #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .valid      (valid),
        .locked     (locked),
        .error      (error),
        .term_count (term_count),
        .expected   (expected),
        .bad_value  (bad_value),
        .wrapped    (wrapped)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: number of accepted terms and the last two of them.
    int n, last1, last2, m_bad;
    bit m_failed, m_err, m_wrap;

    function automatic int req_full();
        if (n == 0) return 0;
        if (n == 1) return 1;
        return last1 + last2;
    endfunction

    task automatic model_reset();
        n = 0; last1 = 0; last2 = 0; m_bad = 0;
        m_failed = 0; m_err = 0; m_wrap = 0;
    endtask

    task automatic model_push(input int d);
        last2 = last1;
        last1 = d;
        n++;
    endtask

    task automatic model_step(input bit r, input bit v, input int d);
        int full;
        if (r) begin
            model_reset();
        end else if (v && !m_failed) begin
            full = req_full();
            if (d == full % 256) begin
                if (n >= 2 && full >= 256) m_wrap = 1;
                model_push(d);
            end else begin
                if (!m_err) m_bad = d;
                m_err = 1;
`ifdef FIB_CHECKER_RESYNC_EN
                if (n >= 2) model_push(d);
                else m_failed = 1;
`else
                m_failed = 1;
`endif
            end
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_model();
        check("locked", int'(locked), (n >= 2 && !m_failed) ? 1 : 0);
        check("error", int'(error), int'(m_err));
        check("term_count", int'(term_count), (n > CNT_MAX) ? CNT_MAX : n);
        check("expected", int'(expected), req_full() % 256);
        check("bad_value", int'(bad_value), m_bad);
        check("wrapped", int'(wrapped), int'(m_wrap));
    endtask

    task automatic step(input bit r, input bit v, input int d);
        @(negedge clk);
        reset = r;
        valid = v;
        value = W'(d);
        @(posedge clk);
        model_step(r, v, d);
        #1;
        check_model();
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) step(1, 0, 0);
    endtask

    typedef struct {
        logic          vld;
        logic [W-1:0]  val;
        logic          lk;
        logic          er;
        logic [CW-1:0] cnt;
        logic [W-1:0]  ex;
        logic [W-1:0]  bad;
        logic          wr;
    } vec_t;

    vec_t tbl[15];

    initial begin
        model_reset();
        tbl[0]  = '{1'b1, 8'd0,  1'b0, 1'b0, 4'd1, 8'd1,  8'd0, 1'b0};
        tbl[1]  = '{1'b1, 8'd1,  1'b1, 1'b0, 4'd2, 8'd1,  8'd0, 1'b0};
        tbl[2]  = '{1'b1, 8'd1,  1'b1, 1'b0, 4'd3, 8'd2,  8'd0, 1'b0};
        tbl[3]  = '{1'b1, 8'd2,  1'b1, 1'b0, 4'd4, 8'd3,  8'd0, 1'b0};
        tbl[4]  = '{1'b1, 8'd3,  1'b1, 1'b0, 4'd5, 8'd5,  8'd0, 1'b0};
        tbl[5]  = '{1'b1, 8'd5,  1'b1, 1'b0, 4'd6, 8'd8,  8'd0, 1'b0};
        tbl[6]  = '{1'b1, 8'd8,  1'b1, 1'b0, 4'd7, 8'd13, 8'd0, 1'b0};
        tbl[7]  = '{1'b1, 8'd13, 1'b1, 1'b0, 4'd8, 8'd21, 8'd0, 1'b0};
        // Rows 8..14 follow a reset: 0,1,1,2,4 then 7.
        tbl[8]  = '{1'b1, 8'd0,  1'b0, 1'b0, 4'd1, 8'd1,  8'd0, 1'b0};
        tbl[9]  = '{1'b1, 8'd1,  1'b1, 1'b0, 4'd2, 8'd1,  8'd0, 1'b0};
        tbl[10] = '{1'b1, 8'd1,  1'b1, 1'b0, 4'd3, 8'd2,  8'd0, 1'b0};
        tbl[11] = '{1'b1, 8'd2,  1'b1, 1'b0, 4'd4, 8'd3,  8'd0, 1'b0};
`ifdef FIB_CHECKER_RESYNC_EN
        tbl[12] = '{1'b1, 8'd4,  1'b1, 1'b1, 4'd5, 8'd6,  8'd4, 1'b0};
        tbl[13] = '{1'b1, 8'd7,  1'b1, 1'b1, 4'd6, 8'd11, 8'd4, 1'b0};
`else
        tbl[12] = '{1'b1, 8'd4,  1'b0, 1'b1, 4'd4, 8'd3,  8'd4, 1'b0};
        tbl[13] = '{1'b1, 8'd7,  1'b0, 1'b1, 4'd4, 8'd3,  8'd4, 1'b0};
`endif
        tbl[14] = '{1'b0, 8'd99, tbl[13].lk, tbl[13].er, tbl[13].cnt, tbl[13].ex, 8'd4, 1'b0};

        do_reset(2);
        check("reset_locked", int'(locked), 0);
        check("reset_count", int'(term_count), 0);
        check("reset_expected", int'(expected), 0);

        for (int i = 0; i < 15; i++) begin
            if (i == 8) do_reset(2);
            step(0, tbl[i].vld, int'(tbl[i].val));
            check($sformatf("tbl%0d_locked", i), int'(locked), int'(tbl[i].lk));
            check($sformatf("tbl%0d_error", i), int'(error), int'(tbl[i].er));
            check($sformatf("tbl%0d_count", i), int'(term_count), int'(tbl[i].cnt));
            check($sformatf("tbl%0d_expected", i), int'(expected), int'(tbl[i].ex));
            check($sformatf("tbl%0d_bad", i), int'(bad_value), int'(tbl[i].bad));
            check($sformatf("tbl%0d_wrapped", i), int'(wrapped), int'(tbl[i].wr));
        end

        // Modular wrap: 0,1,...,144,233,121 then one more term at count saturation.
        do_reset(1);
        begin
            int a, b, t;
            a = 0; b = 1;
            step(0, 1, 0);
            step(0, 1, 1);
            for (int k = 2; k < 15; k++) begin
                t = (a + b) % 256;
                a = b; b = t;
                if (k == 14) check("wrap_before", int'(wrapped), 0);
                step(0, 1, t);
            end
            check("wrap_set", int'(wrapped), 1);
            check("wrap_expected", int'(expected), 98);
            check("wrap_error", int'(error), 0);
            check("wrap_count", int'(term_count), 15);
            step(0, 1, 98);
            check("count_saturated", int'(term_count), 15);
            check("wrap_sticky", int'(wrapped), 1);
        end

        // Bad first term.
        do_reset(1);
        step(0, 1, 5);
        check("first5_error", int'(error), 1);
        check("first5_bad", int'(bad_value), 5);
        check("first5_locked", int'(locked), 0);
        check("first5_count", int'(term_count), 0);

        // Gaps with garbage on value.
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, (k == 0) ? 0 : ((k == 3) ? 2 : 1));
            for (int g = 0; g < 3; g++) step(0, 0, int'($urandom_range(255)));
        end
        check("gap_count", int'(term_count), 4);
        check("gap_expected", int'(expected), 3);
        check("gap_error", int'(error), 0);
        check("gap_locked", int'(locked), 1);

        // Reset beats valid mid-CHECK.
        do_reset(1);
        step(0, 1, 0); step(0, 1, 1); step(0, 1, 1);
        step(0, 1, 2); step(0, 1, 3); step(0, 1, 5);
        check("pre_rst_count", int'(term_count), 6);
        step(1, 1, 3);
        check("rst_locked", int'(locked), 0);
        check("rst_count", int'(term_count), 0);
        check("rst_expected", int'(expected), 0);
        check("rst_error", int'(error), 0);
        step(0, 1, 0);
        step(0, 1, 1);
        check("relock", int'(locked), 1);

        // Random: mostly correct terms, occasional corruption, gaps and resets.
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            bit r, v;
            int d;
            r = ($urandom_range(199) == 0) || (m_failed && $urandom_range(19) == 0);
            v = ($urandom_range(3) != 0);
            d = ($urandom_range(29) == 0) ? int'($urandom_range(255)) : req_full() % 256;
            step(r, v, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
